// File: rtl/cpu_defs.sv
// Shared definitions for the execute stage: opcodes, result classes, defaults
// and the divider state encoding. The divider is built only with EX_MDU_DIV_EN.
package cpu_defs;
   localparam int DW_DEF  = 32;
   localparam int RAW_DEF = 5;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLL   = 8'h7C;
   localparam logic [7:0] OP_SRL   = 8'h02;
   localparam logic [7:0] OP_SRA   = 8'h03;
   localparam logic [7:0] OP_MOVZ  = 8'h0A;
   localparam logic [7:0] OP_MOVN  = 8'h0B;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTLO  = 8'h13;
   localparam logic [7:0] OP_MULT  = 8'h18;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIV   = 8'h1A;
   localparam logic [7:0] OP_DIVU  = 8'h1B;

   localparam logic [2:0] SEL_NOP    = 3'd0;
   localparam logic [2:0] SEL_LOGIC  = 3'd1;
   localparam logic [2:0] SEL_SHIFT  = 3'd2;
   localparam logic [2:0] SEL_MOVE   = 3'd3;
   localparam logic [2:0] SEL_MULDIV = 3'd4;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/ex_mdu_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// start/sgn/op1/op2/cancel are sampled by the divider only while it is idle (cancel always).
interface ex_mdu_if import cpu_defs::*; #(parameter int DW = DW_DEF);
   logic          start;
   logic          sgn;
   logic [DW-1:0] op1;
   logic [DW-1:0] op2;
   logic          cancel;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [DW-1:0] remainder;
   div_state_e    state;

   modport master (output start, sgn, op1, op2, cancel,
                   input  busy, done, quotient, remainder, state);
   modport slave  (input  start, sgn, op1, op2, cancel,
                   output busy, done, quotient, remainder, state);
endinterface

// File: rtl/ex_mdu_div.sv
// Restoring divider, one quotient bit per cycle; operates on magnitudes and
// applies the sign fix-up on the outputs.
module div_iter import cpu_defs::*; #(
   parameter int DW = DW_DEF
) (
   input  logic     clk,
   input  logic     rst,
   ex_mdu_if.slave  dv
);
   localparam int CW = $clog2(DW + 1);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
   logic          negq_q, negq_d, negr_q, negr_d;
   logic [DW:0]   rem_sh, diff;
   logic          busy, done;

   // dvd_q shifts the dividend out at the top and the quotient in at the bottom
   assign rem_sh = {rem_q, dvd_q[DW-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (dv.start && !dv.cancel) begin
               busy   = 1'b1;
               rem_d  = '0;
               negq_d = dv.sgn & (dv.op1[DW-1] ^ dv.op2[DW-1]);
               negr_d = dv.sgn & dv.op1[DW-1];
               if (dv.op2 == '0) begin
                  dvd_d   = '0;
                  negq_d  = 1'b0;
                  negr_d  = 1'b0;
                  state_d = DIV_DONE;
               end else begin
                  dvd_d   = (dv.sgn && dv.op1[DW-1]) ? -dv.op1 : dv.op1;
                  dvs_d   = (dv.sgn && dv.op2[DW-1]) ? -dv.op2 : dv.op2;
                  cnt_d   = CW'(DW);
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            if (dv.cancel) begin
               state_d = DIV_IDLE;
            end else begin
               busy = 1'b1;
               if (!diff[DW]) begin
                  rem_d = diff[DW-1:0];
                  dvd_d = {dvd_q[DW-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[DW-1:0];
                  dvd_d = {dvd_q[DW-2:0], 1'b0};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            done    = !dv.cancel;
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end

   assign dv.busy      = busy;
   assign dv.done      = done;
   assign dv.quotient  = negq_q ? -dvd_q : dvd_q;
   assign dv.remainder = negr_q ? -rem_q : rem_q;
   assign dv.state     = state_q;
endmodule

// File: rtl/ex_mdu.sv
// MIPS execute stage: logic/shift/move, HI/LO transfers, single-cycle multiply and,
// when EX_MDU_DIV_EN is defined, an iterative divider that stalls IF..EX.
module ex_mdu import cpu_defs::*; #(
   parameter int DW  = DW_DEF,
   parameter int RAW = RAW_DEF,
   parameter int OPW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush_i,
   input  logic [OPW-1:0] aluop_i,
   input  logic [2:0]     alusel_i,
   input  logic [DW-1:0]  reg1_i,
   input  logic [DW-1:0]  reg2_i,
   input  logic [RAW-1:0] wd_i,
   input  logic           wreg_i,
   input  logic [DW-1:0]  hi_i,
   input  logic [DW-1:0]  lo_i,
   input  logic           mem_whilo_i,
   input  logic [DW-1:0]  mem_hi_i,
   input  logic [DW-1:0]  mem_lo_i,
   input  logic           wb_whilo_i,
   input  logic [DW-1:0]  wb_hi_i,
   input  logic [DW-1:0]  wb_lo_i,
   output logic           wreg_o,
   output logic [RAW-1:0] wd_o,
   output logic [DW-1:0]  wdata_o,
   output logic           whilo_o,
   output logic [DW-1:0]  hi_o,
   output logic [DW-1:0]  lo_o,
   output logic           stall_req_o
);
   localparam int SAW = $clog2(DW);

   logic [DW-1:0]   hi_fwd, lo_fwd, logic_res, shift_res, move_res;
   logic [2*DW-1:0] prod_s, prod_u;
   logic [SAW-1:0]  sa;
   logic            div_busy, div_done;
   logic [DW-1:0]   div_q, div_r;

   assign hi_fwd = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   assign lo_fwd = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
   assign sa     = reg1_i[SAW-1:0];
   assign prod_s = {{DW{reg1_i[DW-1]}}, reg1_i} * {{DW{reg2_i[DW-1]}}, reg2_i};
   assign prod_u = {{DW{1'b0}}, reg1_i} * {{DW{1'b0}}, reg2_i};

   always_comb begin
      logic_res = '0;
      case (aluop_i)
         OP_AND: logic_res = reg1_i & reg2_i;
         OP_OR:  logic_res = reg1_i | reg2_i;
         OP_XOR: logic_res = reg1_i ^ reg2_i;
         OP_NOR: logic_res = ~(reg1_i | reg2_i);
         default: logic_res = '0;
      endcase
   end

   always_comb begin
      shift_res = '0;
      case (aluop_i)
         OP_SLL: shift_res = reg2_i << sa;
         OP_SRL: shift_res = reg2_i >> sa;
         OP_SRA: shift_res = $signed(reg2_i) >>> sa;
         default: shift_res = '0;
      endcase
   end

   always_comb begin
      move_res = '0;
      case (aluop_i)
         OP_MOVZ, OP_MOVN: move_res = reg1_i;
         OP_MFHI:          move_res = hi_fwd;
         OP_MFLO:          move_res = lo_fwd;
         default:          move_res = '0;
      endcase
   end

`ifdef EX_MDU_DIV_EN
   ex_mdu_if #(.DW(DW)) dv_if ();

   assign dv_if.start  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
   assign dv_if.sgn    = (aluop_i == OP_DIV);
   assign dv_if.op1    = reg1_i;
   assign dv_if.op2    = reg2_i;
   assign dv_if.cancel = flush_i;

   div_iter #(.DW(DW)) u_div (
      .clk (clk),
      .rst (rst),
      .dv  (dv_if)
   );

   assign div_busy = dv_if.busy;
   assign div_done = dv_if.done;
   assign div_q    = dv_if.quotient;
   assign div_r    = dv_if.remainder;
`else
   logic unused_div;
   assign unused_div = ^{clk, flush_i};
   assign div_busy   = 1'b0;
   assign div_done   = 1'b0;
   assign div_q      = '0;
   assign div_r      = '0;
`endif

   // Everything is forced low during reset, including the pass-through fields.
   always_comb begin
      wreg_o      = 1'b0;
      wd_o        = '0;
      wdata_o     = '0;
      whilo_o     = 1'b0;
      hi_o        = '0;
      lo_o        = '0;
      stall_req_o = 1'b0;
      if (rst) begin
         wreg_o      = wreg_i;
         wd_o        = wd_i;
         stall_req_o = div_busy;
         case (alusel_i)
            SEL_LOGIC: wdata_o = logic_res;
            SEL_SHIFT: wdata_o = shift_res;
            SEL_MOVE:  wdata_o = move_res;
            default:   wdata_o = '0;
         endcase
         case (aluop_i)
            OP_MTHI: begin
               whilo_o = 1'b1;
               hi_o    = reg1_i;
               lo_o    = lo_fwd;
            end
            OP_MTLO: begin
               whilo_o = 1'b1;
               hi_o    = hi_fwd;
               lo_o    = reg1_i;
            end
            OP_MULT: begin
               whilo_o     = 1'b1;
               {hi_o, lo_o} = prod_s;
            end
            OP_MULTU: begin
               whilo_o     = 1'b1;
               {hi_o, lo_o} = prod_u;
            end
            default: ;
         endcase
         if (div_done) begin
            whilo_o = 1'b1;
            hi_o    = div_r;
            lo_o    = div_q;
         end
      end
   end
endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed cases plus random operations compared
// against an arithmetic reference model; divider cases compiled with EX_MDU_DIV_EN.
module tb_ex_mdu;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] hi_i, lo_i;
   logic        mem_whilo_i, wb_whilo_i;
   logic [31:0] mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic        wreg_o, whilo_o, stall_req_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ex_mdu dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .hi_i(hi_i), .lo_i(lo_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o),
      .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
      .stall_req_o(stall_req_o)
   );

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_fwd(input logic mw, input logic [31:0] mv,
                                         input logic ww, input logic [31:0] wv,
                                         input logic [31:0] av);
      if (mw) return mv;
      if (ww) return wv;
      return av;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [31:0] r1, input logic [31:0] r2,
                                           input logic [31:0] hf, input logic [31:0] lf);
      int     sh;
      longint v, p2, q;
      sh = int'(r1 % 32);
      case (sel)
         3'd1: begin
            if (op == OP_AND) return r1 & r2;
            if (op == OP_OR)  return r1 | r2;
            if (op == OP_XOR) return r1 ^ r2;
            if (op == OP_NOR) return ~(r1 | r2);
            return 32'd0;
         end
         3'd2: begin
            if (op == OP_SLL) return 32'(longint'(r2) * (longint'(1) << sh));
            if (op == OP_SRL) return 32'(longint'(r2) / (longint'(1) << sh));
            if (op == OP_SRA) begin
               v  = longint'(signed'(r2));
               p2 = longint'(1) << sh;
               q  = v / p2;
               if (v < 0 && q * p2 != v) q = q - 1;
               return 32'(q);
            end
            return 32'd0;
         end
         3'd3: begin
            if (op == OP_MOVZ || op == OP_MOVN) return r1;
            if (op == OP_MFHI) return hf;
            if (op == OP_MFLO) return lf;
            return 32'd0;
         end
         default: return 32'd0;
      endcase
   endfunction

   // {whilo, hi, lo} produced by a non-divide operation
   function automatic logic [64:0] m_hilo(input logic [7:0] op, input logic [31:0] r1,
                                          input logic [31:0] r2, input logic [31:0] hf,
                                          input logic [31:0] lf);
      longint      ps;
      logic [63:0] pu;
      if (op == OP_MTHI) return {1'b1, r1, lf};
      if (op == OP_MTLO) return {1'b1, hf, r1};
      if (op == OP_MULT) begin
         ps = longint'(signed'(r1)) * longint'(signed'(r2));
         return {1'b1, 64'(ps)};
      end
      if (op == OP_MULTU) begin
         pu = {32'd0, r1} * {32'd0, r2};
         return {1'b1, pu};
      end
      return 65'd0;
   endfunction

   function automatic logic [63:0] m_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         return {32'(sa % sb), 32'(sa / sb)};
      end
      return {a % b, a / b};
   endfunction

   // ---------------- driver / check tasks ----------------
   task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2);
      aluop_i  = op;
      alusel_i = sel;
      reg1_i   = r1;
      reg2_i   = r2;
   endtask

   task automatic check_outputs(input string tag);
      logic [31:0] hf, lf;
      hf = m_fwd(mem_whilo_i, mem_hi_i, wb_whilo_i, wb_hi_i, hi_i);
      lf = m_fwd(mem_whilo_i, mem_lo_i, wb_whilo_i, wb_lo_i, lo_i);
      chk({tag, ".wreg"}, 65'(wreg_o), 65'(wreg_i));
      chk({tag, ".wd"}, 65'(wd_o), 65'(wd_i));
      chk({tag, ".wdata"}, 65'(wdata_o), 65'(m_wdata(aluop_i, alusel_i, reg1_i, reg2_i, hf, lf)));
      chk({tag, ".hilo"}, {whilo_o, hi_o, lo_o}, m_hilo(aluop_i, reg1_i, reg2_i, hf, lf));
      chk({tag, ".stall"}, 65'(stall_req_o), 65'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".zero"}, {wreg_o, wd_o, wdata_o, whilo_o, hi_o, lo_o, stall_req_o},
          {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] class_of(input logic [7:0] op);
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_NOR: return SEL_LOGIC;
         OP_SLL, OP_SRL, OP_SRA:        return SEL_SHIFT;
         OP_MOVZ, OP_MOVN, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO: return SEL_MOVE;
         OP_MULT, OP_MULTU:             return SEL_MULDIV;
         default:                       return SEL_NOP;
      endcase
   endfunction

`ifdef EX_MDU_DIV_EN
   // Runs one divide from the idle state and checks stall length and result.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int          cnt;
      logic [63:0] exp;
      set_op(sgn ? OP_DIV : OP_DIVU, SEL_MULDIV, a, b);
      exp = m_div(sgn, a, b);
      cnt = 0;
      @(negedge clk);
      while (stall_req_o === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk({tag, ".stall_cycles"}, 65'(cnt), (b == 32'd0) ? 65'd1 : 65'd33);
      chk({tag, ".result"}, {whilo_o, hi_o, lo_o}, {1'b1, exp});
      chk({tag, ".wdata"}, 65'(wdata_o), 65'd0);
      set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0);
      next_cycle();
      chk({tag, ".after"}, {whilo_o, stall_req_o}, 65'd0);
   endtask
`endif

   initial begin
      logic [7:0] ops [15];
      logic [7:0] op;
      ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MOVZ,
              OP_MOVN, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU};

      // reset with non-trivial inputs applied
      rst = 1'b0; flush_i = 1'b0;
      set_op(OP_MTHI, SEL_LOGIC, 32'h1234_5678, 32'hFFFF_0000);
      wd_i = 5'd7; wreg_i = 1'b1;
      hi_i = 32'h11; lo_i = 32'h22;
      mem_whilo_i = 1'b0; mem_hi_i = '0; mem_lo_i = '0;
      wb_whilo_i = 1'b0; wb_hi_i = '0; wb_lo_i = '0;
      next_cycle();
      next_cycle();
      check_zero("reset");
      rst = 1'b1;
      next_cycle();

      // HI forwarding priority
      set_op(OP_MFHI, SEL_MOVE, 32'd0, 32'd0);
      mem_whilo_i = 1'b1; mem_hi_i = 32'hAAAA_0000;
      wb_whilo_i = 1'b1; wb_hi_i = 32'h1;
      #1 chk("mfhi_mem", 65'(wdata_o), 65'h0_AAAA_0000);
      mem_whilo_i = 1'b0;
      #1 chk("mfhi_wb", 65'(wdata_o), 65'h1);
      wb_whilo_i = 1'b0;
      #1 chk("mfhi_arch", 65'(wdata_o), 65'h11);
      set_op(OP_MTLO, SEL_MOVE, 32'hCAFE_0001, 32'd0);
      wb_whilo_i = 1'b1;
      #1 chk("mtlo", {whilo_o, hi_o, lo_o}, {1'b1, 32'h1, 32'hCAFE_0001});

      // shifts
      wb_whilo_i = 1'b0;
      set_op(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);
      #1 chk("sra", 65'(wdata_o), 65'hF800_0000);
      set_op(OP_SLL, SEL_SHIFT, 32'd4, 32'h8000_0000);
      #1 chk("sll", 65'(wdata_o), 65'h0);

      // multiplies
      set_op(OP_MULT, SEL_MULDIV, 32'hFFFF_FFFD, 32'd5);
      #1 chk("mult", {whilo_o, hi_o, lo_o}, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
      chk("mult.stall", 65'(stall_req_o), 65'd0);
      set_op(OP_MULTU, SEL_MULDIV, 32'hFFFF_FFFF, 32'd2);
      #1 chk("multu", {whilo_o, hi_o, lo_o}, {1'b1, 32'h1, 32'hFFFF_FFFE});
      check_outputs("multu_full");

      // random non-divide operations
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 14)];
         set_op(op, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : class_of(op),
                $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom : $urandom);
         wd_i = 5'($urandom); wreg_i = 1'($urandom);
         hi_i = $urandom; lo_i = $urandom;
         mem_whilo_i = 1'($urandom); mem_hi_i = $urandom; mem_lo_i = $urandom;
         wb_whilo_i = 1'($urandom); wb_hi_i = $urandom; wb_lo_i = $urandom;
         #2 check_outputs("rand");
         next_cycle();
      end
      mem_whilo_i = 1'b0; wb_whilo_i = 1'b0;

`ifdef EX_MDU_DIV_EN
      run_div("div_neg7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
      run_div("divu_by0", 1'b0, 32'd5, 32'd0);
      run_div("div_min_neg1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++)
         run_div("div_rand", 1'($urandom), $urandom,
                 ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31)));

      // flush in the middle of a divide
      set_op(OP_DIV, SEL_MULDIV, 32'd1000, 32'd3);
      repeat (11) next_cycle();
      chk("flush.busy", 65'(stall_req_o), 65'd1);
      flush_i = 1'b1;
      #1 chk("flush.same_cycle", {whilo_o, stall_req_o}, 65'd0);
      next_cycle();
      flush_i = 1'b0;
      set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0);
      #1 chk("flush.idle", {whilo_o, stall_req_o}, 65'd0);
      run_div("after_flush", 1'b0, 32'd100, 32'd7);

      // reset in the middle of a divide
      set_op(OP_DIVU, SEL_MULDIV, 32'd12345, 32'd6);
      repeat (11) next_cycle();
      rst = 1'b0;
      #1 check_zero("rst_mid.comb");
      next_cycle();
      check_zero("rst_mid.edge");
      set_op(OP_NOP, SEL_NOP, 32'd0, 32'd0);
      rst = 1'b1;
      #1 chk("rst_mid.idle", {whilo_o, stall_req_o}, 65'd0);
      run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7);
`else
      // without the divider, divide opcodes are no-ops
      set_op(OP_DIV, SEL_MULDIV, 32'hFFFF_FFF9, 32'd2);
      for (int i = 0; i < 3; i++) begin
         #1 check_outputs("div_nop");
         next_cycle();
      end
      set_op(OP_DIVU, SEL_MULDIV, 32'd5, 32'd0);
      #1 check_outputs("divu_nop");
      next_cycle();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
